// File: rtl/craps_controller.sv
`default_nettype none
// ============================================================================
//  Module      : craps_controller
//  Description : Game-sequencing FSM downstream of the craps datapath.
//                Synchronises the roll button, drives the datapath roll
//                enable and set-point strobe, reports win/lose and keeps
//                saturating win/loss tallies.
//  Revision    : 1.0  initial release
// ============================================================================
module craps_controller #(
    parameter int PIPE_DEPTH = 4,
    parameter int CNT_W      = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             roll_btn,
    input  logic             natural,
    input  logic             craps,
    input  logic             seven_out,
    input  logic             eq,
    output logic             roll,
    output logic             sp,
    output logic             point_phase,
    output logic             win,
    output logic             lose,
    output logic [3:0]       state_dbg,
    output logic [CNT_W-1:0] wins,
    output logic [CNT_W-1:0] losses
);

    // Flush counter must hold PIPE_DEPTH-1; keep at least one bit.
    localparam int FC_W = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
    localparam logic [FC_W-1:0] FLUSH_LOAD = FC_W'(PIPE_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_ROLL1  = 4'd1;
    localparam logic [3:0] ST_FLUSH1 = 4'd2;
    localparam logic [3:0] ST_EVAL1  = 4'd3;
    localparam logic [3:0] ST_POINT  = 4'd4;
    localparam logic [3:0] ST_ROLLN  = 4'd5;
    localparam logic [3:0] ST_FLUSHN = 4'd6;
    localparam logic [3:0] ST_EVALN  = 4'd7;
    localparam logic [3:0] ST_WIN    = 4'd8;
    localparam logic [3:0] ST_LOSE   = 4'd9;

    logic [3:0]      state;
    logic [3:0]      next_state;
    logic [FC_W-1:0] flush_cnt;
    logic            sync_ff;
    logic            btn_s;
    logic            btn_d;
    logic            press;
    logic            win_evt;
    logic            lose_evt;

    // Two-flop synchroniser plus one delay stage for rising-edge detection.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_ff <= 1'b0;
            btn_s   <= 1'b0;
            btn_d   <= 1'b0;
        end else begin
            sync_ff <= roll_btn;
            btn_s   <= sync_ff;
            btn_d   <= btn_s;
        end
    end

    // A press is a fresh 0->1 of the synchronised button; a held button never re-triggers.
    assign press = btn_s & ~btn_d;

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Flush counter: preloaded while rolling, counts down while flushing the datapath.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            flush_cnt <= '0;
        end else if (state == ST_ROLL1 || state == ST_ROLLN) begin
            flush_cnt <= FLUSH_LOAD;
        end else if ((state == ST_FLUSH1 || state == ST_FLUSHN) && flush_cnt != '0) begin
            flush_cnt <= flush_cnt - FC_W'(1);
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (press) next_state = ST_ROLL1;
            ST_ROLL1:  if (!btn_s) next_state = ST_FLUSH1;
            ST_FLUSH1: if (flush_cnt == '0) next_state = ST_EVAL1;
            ST_EVAL1: begin
                // natural outranks craps when the datapath reports both
                if (natural)    next_state = ST_WIN;
                else if (craps) next_state = ST_LOSE;
                else            next_state = ST_POINT;
            end
            ST_POINT:  if (press) next_state = ST_ROLLN;
            ST_ROLLN:  if (!btn_s) next_state = ST_FLUSHN;
            ST_FLUSHN: if (flush_cnt == '0) next_state = ST_EVALN;
            ST_EVALN: begin
                // making the point outranks a seven
                if (eq)             next_state = ST_WIN;
                else if (seven_out) next_state = ST_LOSE;
                else                next_state = ST_POINT;
            end
            ST_WIN:    if (press) next_state = ST_ROLL1;
            ST_LOSE:   if (press) next_state = ST_ROLL1;
            default:   next_state = ST_IDLE;
        endcase
    end

    // Moore output decode; sp qualifies EVAL1 with the flags that select the point path.
    always_comb begin
        roll        = 1'b0;
        sp          = 1'b0;
        point_phase = 1'b0;
        win         = 1'b0;
        lose        = 1'b0;
        case (state)
            ST_ROLL1, ST_FLUSH1: roll = 1'b1;
            ST_EVAL1:            sp   = ~natural & ~craps;
            ST_POINT, ST_EVALN:  point_phase = 1'b1;
            ST_ROLLN, ST_FLUSHN: begin
                roll        = 1'b1;
                point_phase = 1'b1;
            end
            ST_WIN:              win  = 1'b1;
            ST_LOSE:             lose = 1'b1;
            default:             roll = 1'b0;
        endcase
    end

    assign state_dbg = state;
    assign win_evt   = (next_state == ST_WIN)  && (state == ST_EVAL1 || state == ST_EVALN);
    assign lose_evt  = (next_state == ST_LOSE) && (state == ST_EVAL1 || state == ST_EVALN);

    // Saturating tallies, bumped on the transition into WIN/LOSE.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wins   <= '0;
            losses <= '0;
        end else begin
            if (win_evt && wins != CNT_MAX) begin
                wins <= wins + CNT_W'(1);
            end
            if (lose_evt && losses != CNT_MAX) begin
                losses <= losses + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_craps_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_craps_controller
//  Description : Directed self-checking bench for craps_controller.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_craps_controller;

    localparam int PD = 4;
    localparam int CW = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          roll_btn = 1'b0;
    logic          natural = 1'b0;
    logic          craps = 1'b0;
    logic          seven_out = 1'b0;
    logic          eq = 1'b0;
    logic          roll;
    logic          sp;
    logic          point_phase;
    logic          win;
    logic          lose;
    logic [3:0]    state_dbg;
    logic [CW-1:0] wins;
    logic [CW-1:0] losses;

    int n_checks = 0;
    int n_errors = 0;
    int rc;
    int spc;
    int ev_idx;

    craps_controller #(.PIPE_DEPTH(PD), .CNT_W(CW)) dut (
        .clock       (clock),
        .reset       (reset),
        .roll_btn    (roll_btn),
        .natural     (natural),
        .craps       (craps),
        .seven_out   (seven_out),
        .eq          (eq),
        .roll        (roll),
        .sp          (sp),
        .point_phase (point_phase),
        .win         (win),
        .lose        (lose),
        .state_dbg   (state_dbg),
        .wins        (wins),
        .losses      (losses)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_flags(input logic n, input logic c, input logic s, input logic e);
        natural = n; craps = c; seven_out = s; eq = e;
    endtask

    task automatic do_reset();
        roll_btn = 1'b0;
        reset = 1'b0;
        step();
        step();
        check_val("rst_state", state_dbg, 0);
        check_val("rst_outs", {roll, sp, point_phase, win, lose}, 0);
        check_val("rst_wins", wins, 0);
        check_val("rst_losses", losses, 0);
        reset = 1'b1;
        step();
    endtask

    // Press for 'hold' cycles, release, and run until the roll resolves.
    task automatic play_roll(input int hold);
        bit done;
        rc = 0; spc = 0; ev_idx = -1; done = 1'b0;
        roll_btn = 1'b1;
        for (int i = 0; i < hold + 40 && !done; i++) begin
            if (i == hold) roll_btn = 1'b0;
            step();
            rc  += int'(roll);
            spc += int'(sp);
            if ((state_dbg == 4'd3 || state_dbg == 4'd7) && ev_idx < 0) ev_idx = i;
            if (i >= hold && rc > 0 && !roll &&
                (state_dbg == 4'd4 || state_dbg == 4'd8 || state_dbg == 4'd9)) done = 1'b1;
        end
        check_val("roll_resolved", done, 1);
    endtask

    task automatic wait_state(input string tag, input logic [3:0] target, input int limit);
        for (int i = 0; i < limit && state_dbg != target; i++) step();
        check_val(tag, state_dbg, target);
    endtask

    initial begin
        // 1: natural on first roll, 6-cycle hold
        do_reset();
        set_flags(1, 0, 0, 0);
        play_roll(6);
        check_val("t1_roll_cycles", rc, 6 + PD);
        check_val("t1_eval_latency", ev_idx, 6 + 2 + PD);
        check_val("t1_sp", spc, 0);
        check_val("t1_win", win, 1);
        check_val("t1_lose", lose, 0);
        check_val("t1_wins", wins, 1);
        check_val("t1_state", state_dbg, 8);

        // 2: craps on first roll
        do_reset();
        set_flags(0, 1, 0, 0);
        play_roll(2);
        check_val("t2_lose", lose, 1);
        check_val("t2_losses", losses, 1);
        check_val("t2_point_phase", point_phase, 0);
        check_val("t2_sp", spc, 0);
        check_val("t2_wins", wins, 0);

        // 3: point established, then made
        do_reset();
        set_flags(0, 0, 0, 0);
        play_roll(3);
        check_val("t3_sp_pulses", spc, 1);
        check_val("t3_point_phase", point_phase, 1);
        check_val("t3_state", state_dbg, 4);
        set_flags(0, 0, 0, 1);
        play_roll(3);
        check_val("t3n_roll_cycles", rc, 3 + PD);
        check_val("t3n_eval_latency", ev_idx, 3 + 2 + PD);
        check_val("t3n_sp", spc, 0);
        check_val("t3n_win", win, 1);
        check_val("t3n_wins", wins, 1);
        check_val("t3n_point_phase", point_phase, 0);

        // 4: seven out, then eq beats seven_out, then natural beats craps
        set_flags(0, 0, 0, 0);
        play_roll(1);
        check_val("t4_point", state_dbg, 4);
        set_flags(0, 0, 1, 0);
        play_roll(2);
        check_val("t4_seven_lose", lose, 1);
        check_val("t4_losses", losses, 1);
        set_flags(0, 0, 0, 0);
        play_roll(1);
        check_val("t4_point2", state_dbg, 4);
        set_flags(0, 0, 1, 1);
        play_roll(2);
        check_val("t4_eq_prio_win", win, 1);
        check_val("t4_wins", wins, 2);
        set_flags(1, 1, 0, 0);
        play_roll(1);
        check_val("t4_nat_prio_win", state_dbg, 8);
        check_val("t4_wins3", wins, 3);
        check_val("t4_losses_kept", losses, 1);

        // 5: asynchronous reset in the middle of FLUSH1
        set_flags(0, 0, 0, 0);
        roll_btn = 1'b1;
        step();
        step();
        roll_btn = 1'b0;
        wait_state("t5_reach_flush", 4'd2, 20);
        reset = 1'b0;
        #1;
        check_val("t5_roll", roll, 0);
        check_val("t5_sp", sp, 0);
        check_val("t5_state", state_dbg, 0);
        check_val("t5_wins", wins, 0);
        check_val("t5_losses", losses, 0);
        step();
        reset = 1'b1;
        repeat (6) step();
        check_val("t5_idle_hold", state_dbg, 0);
        roll_btn = 1'b1;
        wait_state("t5_new_press", 4'd1, 10);
        roll_btn = 1'b0;

        // 6: win saturation, loss still counts, held button after WIN
        do_reset();
        set_flags(1, 0, 0, 0);
        for (int g = 0; g < 260; g++) play_roll(1);
        check_val("t6_wins_sat", wins, 255);
        check_val("t6_losses_zero", losses, 0);
        set_flags(0, 1, 0, 0);
        play_roll(1);
        check_val("t6_loss_inc", losses, 1);
        check_val("t6_wins_hold", wins, 255);
        // button pressed during flush and still held when WIN is reached
        set_flags(1, 0, 0, 0);
        roll_btn = 1'b1;
        step();
        roll_btn = 1'b0;
        wait_state("t6_flush", 4'd2, 20);
        roll_btn = 1'b1;
        wait_state("t6_win", 4'd8, 20);
        repeat (10) step();
        check_val("t6_held_no_restart", state_dbg, 8);
        check_val("t6_held_roll", roll, 0);
        roll_btn = 1'b0;
        repeat (4) step();
        check_val("t6_released", state_dbg, 8);
        roll_btn = 1'b1;
        repeat (4) step();
        check_val("t6_repress", state_dbg, 1);
        check_val("t6_repress_roll", roll, 1);
        roll_btn = 1'b0;
        repeat (10) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
